// File: rtl/rvne_pipe_pkg.sv
// Shared types and default widths for the elastic inter-stage registers
// of the scalar/vector (WVR/SVR/NSR) datapath.
package rvne_pipe_pkg;

   localparam int WVR_W       = 512;
   localparam int SVR_W       = 128;
   localparam int NSR_W       = 32;
   localparam int OPND_W      = 32;
   localparam int IMM_W       = 32;
   localparam int REGIDX_W    = 5;
   localparam int CTRL_FLAG_W = 9;

   // Register indices ride in the control vector so that bubbles zero them too.
   localparam int DEF_DATA_W = WVR_W + SVR_W + NSR_W + 2 * OPND_W + IMM_W;
   localparam int DEF_CTRL_W = 3 * REGIDX_W + CTRL_FLAG_W;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } stage_state_e;

   function automatic logic [1:0] beats_held(input stage_state_e s);
      case (s)
         ONE:     return 2'd1;
         FULL:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (inc && (r_count != {CNT_W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: valid/ready handshake, optional 2-entry
// skid buffer, synchronous flush and saturating stall/flush counters.
module pipe_stage_skid
   import rvne_pipe_pkg::*;
#(
   parameter int CTRL_W     = DEF_CTRL_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int SKID       = 1,
   parameter int CLEAR_DATA = 0,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   stage_state_e      r_state;
   logic              r_out_valid;
   logic              r_in_ready;
   logic [CTRL_W-1:0] r_m_ctrl;
   logic [CTRL_W-1:0] r_s_ctrl;
   logic [DATA_W-1:0] r_m_data;
   logic [DATA_W-1:0] r_s_data;

   logic w_in_ready;
   logic w_push;
   logic w_pop;
   logic w_m_load;
   logic w_m_from_s;
   logic w_s_load;
   logic w_kill;
   logic w_stall;

   // Without the skid entry FULL is unreachable: a push into ONE implies a pop.
   assign w_in_ready = (SKID != 0) ? r_in_ready : (!r_out_valid || out_ready);
   assign w_push     = in_valid && w_in_ready;
   assign w_pop      = r_out_valid && out_ready;

   always_comb begin
      w_m_load   = 1'b0;
      w_m_from_s = 1'b0;
      w_s_load   = 1'b0;
      if (!flush) begin
         case (r_state)
            EMPTY: w_m_load = w_push;
            ONE: begin
               w_m_load = w_push && w_pop;
               w_s_load = w_push && !w_pop;
            end
            FULL: begin
               w_m_load   = w_pop;
               w_m_from_s = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_m_ctrl    <= '0;
         r_s_ctrl    <= '0;
      end else if (flush) begin
         r_state     <= EMPTY;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
         r_m_ctrl    <= '0;
         r_s_ctrl    <= '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_push) begin
                  r_state     <= ONE;
                  r_out_valid <= 1'b1;
               end
            end
            ONE: begin
               if (w_push && !w_pop) begin
                  r_state    <= FULL;
                  r_in_ready <= 1'b0;
               end else if (!w_push && w_pop) begin
                  r_state     <= EMPTY;
                  r_out_valid <= 1'b0;
               end
            end
            FULL: begin
               if (w_pop) begin
                  r_state    <= ONE;
                  r_in_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= EMPTY;
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
            end
         endcase
         if (w_m_load) r_m_ctrl <= w_m_from_s ? r_s_ctrl : in_ctrl;
         if (w_s_load) r_s_ctrl <= in_ctrl;
      end
   end

   generate
      if (CLEAR_DATA != 0) begin : g_clear_data
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_m_data <= '0;
               r_s_data <= '0;
            end else if (flush) begin
               r_m_data <= '0;
               r_s_data <= '0;
            end else begin
               if (w_m_load) r_m_data <= w_m_from_s ? r_s_data : in_data;
               if (w_s_load) r_s_data <= in_data;
            end
         end
         assign out_data = r_out_valid ? r_m_data : '0;
      end else begin : g_hold_data
         // Wide payload left unreset and untouched by flush to save toggling.
         always_ff @(posedge clk) begin
            if (w_m_load) r_m_data <= w_m_from_s ? r_s_data : in_data;
            if (w_s_load) r_s_data <= in_data;
         end
         assign out_data = r_m_data;
      end
   endgenerate

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_ctrl  = r_out_valid ? r_m_ctrl : '0;

   // A flush only counts when some held beat was not already leaving.
   assign w_kill  = flush && (beats_held(r_state) > {1'b0, w_pop});
   assign w_stall = r_out_valid && !out_ready;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_stall),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (w_kill),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: a SKID=1/CLEAR_DATA=1/CNT_W=4 instance and a
// SKID=0/CLEAR_DATA=0 instance share stimulus; each is tracked by a queue model.
module tb_pipe_stage_skid;

   localparam int CW = 24;
   localparam int DW = 768;

   logic          clk;
   logic          reset;
   logic          fl;
   logic          iv;
   logic          ordy;
   logic [CW-1:0] ictrl;
   logic [DW-1:0] idata;

   logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid;
   logic [CW-1:0] a_out_ctrl, b_out_ctrl;
   logic [DW-1:0] a_out_data, b_out_data;
   logic [3:0]    a_stall, a_flush;
   logic [15:0]   b_stall, b_flush;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } beat_t;

   beat_t qa[$];
   beat_t qb[$];
   int sta, fla, stb, flb;

   typedef struct packed {
      logic          v, f, r;
      logic [CW-1:0] c;
      logic          e_ov;
      logic [CW-1:0] e_c;
      logic          e_ir;
      logic [7:0]    e_st;
      logic [7:0]    e_fl;
   } vec_t;

   vec_t tbl[18];

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(1), .CNT_W(4)) u_dut_a (
      .clk(clk), .reset(reset), .flush(fl), .in_valid(iv), .in_ready(a_in_ready),
      .in_ctrl(ictrl), .in_data(idata), .out_valid(a_out_valid), .out_ready(ordy),
      .out_ctrl(a_out_ctrl), .out_data(a_out_data), .stall_cnt(a_stall), .flush_cnt(a_flush)
   );

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLEAR_DATA(0), .CNT_W(16)) u_dut_b (
      .clk(clk), .reset(reset), .flush(fl), .in_valid(iv), .in_ready(b_in_ready),
      .in_ctrl(ictrl), .in_data(idata), .out_valid(b_out_valid), .out_ready(ordy),
      .out_ctrl(b_out_ctrl), .out_data(b_out_data), .stall_cnt(b_stall), .flush_cnt(b_flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [DW-1:0] mkdata(input logic [CW-1:0] c);
      return {32{c}};
   endfunction

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic f, input logic r,
                        input logic [CW-1:0] c, input logic [DW-1:0] d);
      iv = v; fl = f; ordy = r; ictrl = c; idata = d;
   endtask

   task automatic clear_models();
      qa.delete(); qb.delete();
      sta = 0; fla = 0; stb = 0; flb = 0;
   endtask

   // Called between edges: checks current outputs, then advances both models.
   task automatic model_cmp();
      logic  ir, pop, push;
      beat_t nb;
      beat_t hd;
      nb.c = ictrl;
      nb.d = idata;

      ir = (qa.size() < 2);
      hd = (qa.size() != 0) ? qa[0] : '0;
      chk("a_in_ready", a_in_ready, ir);
      chk("a_out_valid", a_out_valid, qa.size() != 0);
      chk("a_out_ctrl", a_out_ctrl, hd.c);
      chk("a_out_data", a_out_data, hd.d);
      chk("a_stall_cnt", a_stall, sta);
      chk("a_flush_cnt", a_flush, fla);
      pop  = (qa.size() != 0) && ordy;
      push = iv && ir;
      if (qa.size() != 0 && !ordy && sta < 15) sta++;
      if (fl) begin
         if (qa.size() > int'(pop) && fla < 15) fla++;
         qa.delete();
      end else begin
         if (pop) void'(qa.pop_front());
         if (push) qa.push_back(nb);
      end

      ir = (qb.size() == 0) || ordy;
      hd = (qb.size() != 0) ? qb[0] : '0;
      chk("b_in_ready", b_in_ready, ir);
      chk("b_out_valid", b_out_valid, qb.size() != 0);
      chk("b_out_ctrl", b_out_ctrl, hd.c);
      if (qb.size() != 0) chk("b_out_data", b_out_data, hd.d);
      chk("b_stall_cnt", b_stall, stb);
      chk("b_flush_cnt", b_flush, flb);
      pop  = (qb.size() != 0) && ordy;
      push = iv && ir;
      if (qb.size() != 0 && !ordy && stb < 65535) stb++;
      if (fl) begin
         if (qb.size() > int'(pop) && flb < 65535) flb++;
         qb.delete();
      end else begin
         if (pop) void'(qb.pop_front());
         if (push) qb.push_back(nb);
      end
   endtask

   task automatic step(input logic v, input logic f, input logic r,
                       input logic [CW-1:0] c, input logic [DW-1:0] d);
      drive(v, f, r, c, d);
      @(negedge clk);
      model_cmp();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [DW-1:0] rd;
      logic [CW-1:0] rc;

      // v, f, r, ctrl, exp out_valid, exp out_ctrl, exp in_ready, exp stall, exp flush
      tbl[0]  = '{1'b1, 1'b0, 1'b1, 24'h0000A5, 1'b0, 24'h0,      1'b1, 8'd0, 8'd0};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 24'h0,      1'b1, 24'h0000A5, 1'b1, 8'd0, 8'd0};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 24'h0,      1'b0, 24'h0,      1'b1, 8'd0, 8'd0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 24'd1,      1'b0, 24'h0,      1'b1, 8'd0, 8'd0};
      tbl[4]  = '{1'b1, 1'b0, 1'b0, 24'd2,      1'b1, 24'd1,      1'b1, 8'd0, 8'd0};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 24'd3,      1'b1, 24'd1,      1'b0, 8'd1, 8'd0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 24'd3,      1'b1, 24'd1,      1'b0, 8'd2, 8'd0};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 24'd3,      1'b1, 24'd1,      1'b0, 8'd3, 8'd0};
      tbl[8]  = '{1'b1, 1'b0, 1'b1, 24'd3,      1'b1, 24'd2,      1'b1, 8'd3, 8'd0};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 24'h0,      1'b1, 24'd3,      1'b1, 8'd3, 8'd0};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 24'h0,      1'b0, 24'h0,      1'b1, 8'd3, 8'd0};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 24'd4,      1'b0, 24'h0,      1'b1, 8'd3, 8'd0};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 24'd5,      1'b1, 24'd4,      1'b1, 8'd3, 8'd0};
      tbl[13] = '{1'b1, 1'b1, 1'b0, 24'd9,      1'b1, 24'd4,      1'b0, 8'd4, 8'd0};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 24'h0,      1'b0, 24'h0,      1'b1, 8'd5, 8'd1};
      tbl[15] = '{1'b1, 1'b0, 1'b1, 24'd6,      1'b0, 24'h0,      1'b1, 8'd5, 8'd1};
      tbl[16] = '{1'b1, 1'b1, 1'b1, 24'd7,      1'b1, 24'd6,      1'b1, 8'd5, 8'd1};
      tbl[17] = '{1'b0, 1'b0, 1'b1, 24'h0,      1'b0, 24'h0,      1'b1, 8'd5, 8'd1};

      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      clear_models();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_a_out_valid", a_out_valid, 1'b0);
      chk("reset_a_out_ctrl", a_out_ctrl, '0);
      chk("reset_a_out_data", a_out_data, '0);
      chk("reset_a_in_ready", a_in_ready, 1'b1);
      chk("reset_a_counters", {a_stall, a_flush}, '0);
      chk("reset_b_out_valid", b_out_valid, 1'b0);
      chk("reset_b_in_ready", b_in_ready, 1'b1);
      chk("reset_b_counters", {b_stall, b_flush}, '0);
      @(posedge clk);
      #1;

      // Full-rate stream: eight beats back to back, never stalled.
      for (int k = 1; k <= 9; k++) begin
         drive(k <= 8, 1'b0, 1'b1, CW'(k), mkdata(CW'(k)));
         @(negedge clk);
         chk("stream_in_ready", a_in_ready, 1'b1);
         if (k > 1) begin
            chk("stream_out_valid", a_out_valid, 1'b1);
            chk("stream_out_ctrl", a_out_ctrl, CW'(k - 1));
         end
         model_cmp();
         @(posedge clk);
         #1;
      end
      chk("stream_stall_cnt", a_stall, 4'd0);

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].v, tbl[i].f, tbl[i].r, tbl[i].c, mkdata(tbl[i].c));
         @(negedge clk);
         chk($sformatf("vec%0d_out_valid", i), a_out_valid, tbl[i].e_ov);
         chk($sformatf("vec%0d_out_ctrl", i), a_out_ctrl, tbl[i].e_c);
         chk($sformatf("vec%0d_out_data", i), a_out_data,
             tbl[i].e_ov ? mkdata(tbl[i].e_c) : '0);
         chk($sformatf("vec%0d_in_ready", i), a_in_ready, tbl[i].e_ir);
         chk($sformatf("vec%0d_stall_cnt", i), a_stall, tbl[i].e_st);
         chk($sformatf("vec%0d_flush_cnt", i), a_flush, tbl[i].e_fl);
         model_cmp();
         @(posedge clk);
         #1;
      end

      // Stall saturation on the 4-bit counters.
      step(1'b1, 1'b0, 1'b0, 24'hABCDEF, mkdata(24'hABCDEF));
      repeat (20) step(1'b0, 1'b0, 1'b0, '0, '0);
      chk("sat_stall_cnt", a_stall, 4'hF);

      for (int n = 0; n < 400; n++) begin
         for (int w = 0; w < DW / 32; w++) rd[w*32 +: 32] = $urandom;
         rc = CW'($urandom);
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 2) != 0), rc, rd);
      end

      // Asynchronous reset in the middle of a clock-high phase while FULL.
      step(1'b0, 1'b1, 1'b1, '0, '0);
      step(1'b1, 1'b0, 1'b0, 24'd11, mkdata(24'd11));
      step(1'b1, 1'b0, 1'b0, 24'd12, mkdata(24'd12));
      chk("pre_areset_a_full", a_in_ready, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      chk("areset_a_out_valid", a_out_valid, 1'b0);
      chk("areset_a_out_ctrl", a_out_ctrl, '0);
      chk("areset_a_out_data", a_out_data, '0);
      chk("areset_a_in_ready", a_in_ready, 1'b1);
      chk("areset_a_counters", {a_stall, a_flush}, '0);
      chk("areset_b_out_valid", b_out_valid, 1'b0);
      chk("areset_b_out_ctrl", b_out_ctrl, '0);
      chk("areset_b_counters", {b_stall, b_flush}, '0);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      reset = 1'b0;
      clear_models();
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 1'b1, 24'd21, mkdata(24'd21));
      step(1'b0, 1'b0, 1'b1, '0, '0);
      step(1'b0, 1'b0, 1'b1, '0, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
